// File: rtl/fb_access_arbiter_if.sv
// fb_access_arbiter_if
// Bundles everything the framebuffer arbiter exchanges with the rest of the
// system: the VGA raster counts, the two game-logic write requesters, the
// single framebuffer RAM port and the scan-out pixel/frame outputs.
//
// Signals:
//   hCount, vCount    raster position from the VGA timing block
//   wr_blank_only     restrict writes to the blanking interval
//   wr_req[1:0]       level write requests, held until acked
//   wr_addr0/1        write address per requester
//   wr_data0/1        write data per requester
//   wr_ack[1:0]       one-cycle ack per requester
//   wr_err            sticky out-of-range write flag
//   mem_addr/we/wdata framebuffer RAM port (driven by the arbiter)
//   mem_rdata         framebuffer RAM read data (1-cycle latency)
//   pix_data          current pixel colour
//   frame_start       pulse when the raster wraps to (0,0)
//
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system's view (raster, requesters, RAM)
interface fb_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic [9:0]        hCount;
  logic [9:0]        vCount;
  logic              wr_blank_only;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_ack;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              frame_start;

  modport slave (
    input  hCount, vCount, wr_blank_only, wr_req,
    input  wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_we, mem_wdata, pix_data, frame_start
  );

  modport master (
    output hCount, vCount, wr_blank_only, wr_req,
    output wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata, pix_data, frame_start
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter
// Shares the single port of the 160x120 framebuffer RAM between VGA scan-out
// and two game-logic writers. Each new visible raster pixel steals exactly one
// cycle for a scan read; every other cycle is a write slot granted
// round-robin, optionally only while the raster is in blanking.
//
// Ports:
//   clk      system clock (raster advances once per 4 clk)
//   reset_n  asynchronous active-low reset
//   bus      fb_access_arbiter_if.slave (raster, requesters, RAM, pixel out)
module fb_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input logic                 clk,
  input logic                 reset_n,
  fb_access_arbiter_if.slave  bus
);

  localparam logic [9:0]        H_VIS_FIRST = 10'd144;
  localparam logic [9:0]        H_VIS_LAST  = 10'd783;
  localparam logic [9:0]        V_VIS_FIRST = 10'd35;
  localparam logic [9:0]        V_VIS_LAST  = 10'd514;
  localparam logic [ADDR_W-1:0] ADDR_MAX    = ADDR_W'(19199);

  logic [9:0]        r_hD;
  logic              r_rr;
  logic              r_scanD;
  logic [ADDR_W-1:0] r_lastAddr;
  logic [DATA_W-1:0] r_pix;
  logic              r_err;

  logic              w_newPx;
  logic              w_visible;
  logic              w_scan;
  logic [7:0]        w_x;
  logic [6:0]        w_y;
  logic [ADDR_W-1:0] w_scanAddr;
  logic              w_wrOpen;
  logic [1:0]        w_elig;
  logic              w_grant;
  logic              w_sel;
  logic [ADDR_W-1:0] w_gAddr;
  logic [DATA_W-1:0] w_gData;
  logic              w_inRange;
  logic [ADDR_W-1:0] w_memAddr;
  logic              w_memWe;
  logic [DATA_W-1:0] w_memWdata;
  logic [1:0]        w_wrAck;

  // A raster step is detected by comparing hCount with last cycle's copy,
  // so one scan cycle fires per pixel no matter how long the pixel lasts.
  assign w_newPx   = (bus.hCount != r_hD);
  assign w_visible = (bus.hCount >= H_VIS_FIRST) && (bus.hCount <= H_VIS_LAST) &&
                     (bus.vCount >= V_VIS_FIRST) && (bus.vCount <= V_VIS_LAST);

  // Everything combinational that reaches an output is gated by reset_n so
  // the RAM port and acks go quiet the instant reset is asserted.
  assign w_scan = reset_n && w_newPx && w_visible;

  // Each framebuffer texel covers 4x4 raster pixels; y*160 is built from
  // two shifts to avoid a multiplier.
  assign w_x        = 8'((bus.hCount - H_VIS_FIRST) >> 2);
  assign w_y        = 7'((bus.vCount - V_VIS_FIRST) >> 2);
  assign w_scanAddr = ADDR_W'({w_y, 7'b0}) + ADDR_W'({w_y, 5'b0}) + ADDR_W'(w_x);

  // Writers only see the slot when the scan path does not need it and, in
  // blank-only mode, when the raster is off screen.
  assign w_wrOpen  = !bus.wr_blank_only || !w_visible;
  assign w_elig    = bus.wr_req & {2{w_wrOpen}};
  assign w_grant   = reset_n && !w_scan && (w_elig != 2'b00);
  assign w_sel     = (w_elig == 2'b11) ? r_rr : w_elig[1];
  assign w_gAddr   = w_sel ? bus.wr_addr1 : bus.wr_addr0;
  assign w_gData   = w_sel ? bus.wr_data1 : bus.wr_data0;
  assign w_inRange = (w_gAddr <= ADDR_MAX);

  // RAM port mux: scan has absolute priority, then the granted writer.
  // Out-of-range writes are still acked so the requester can move on, but
  // the write enable is suppressed. When idle the address is parked on its
  // last value to avoid needless toggling on the RAM address bus.
  always_comb begin
    w_memAddr  = r_lastAddr;
    w_memWe    = 1'b0;
    w_memWdata = '0;
    w_wrAck    = 2'b00;
    if (w_scan) begin
      w_memAddr = w_scanAddr;
    end else if (w_grant) begin
      w_memAddr  = w_gAddr;
      w_memWdata = w_gData;
      w_memWe    = w_inRange;
      w_wrAck    = w_sel ? 2'b10 : 2'b01;
    end
  end

  assign bus.mem_addr    = w_memAddr;
  assign bus.mem_we      = w_memWe;
  assign bus.mem_wdata   = w_memWdata;
  assign bus.wr_ack      = w_wrAck;
  assign bus.wr_err      = r_err;
  assign bus.pix_data    = r_pix;
  assign bus.frame_start = reset_n && w_newPx &&
                           (bus.hCount == 10'd0) && (bus.vCount == 10'd0);

  // Raster history, scan pipeline flag and the parked RAM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hD       <= 10'd0;
      r_scanD    <= 1'b0;
      r_lastAddr <= '0;
    end else begin
      r_hD       <= bus.hCount;
      r_scanD    <= w_scan;
      r_lastAddr <= w_memAddr;
    end
  end

  // Round-robin pointer points at whoever lost (or was not granted) last,
  // and the error flag latches any acked out-of-range write until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_grant) begin
      r_rr <= ~w_sel;
      if (!w_inRange) begin
        r_err <= 1'b1;
      end
    end
  end

  // The RAM answers one cycle after the scan address, so the pixel register
  // loads on the following cycle. Off screen the pixel is forced to black.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix <= '0;
    end else if (r_scanD) begin
      r_pix <= bus.mem_rdata;
    end else if (!w_visible) begin
      r_pix <= '0;
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter
// Directed bench for fb_access_arbiter: drives the raster and both write
// requesters, models the synchronous framebuffer RAM, and compares the arbiter
// outputs against hand-computed values. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_fb_access_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 19200;

  logic clk;
  logic reset_n;
  int   checks;
  int   fails;

  fb_access_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fb_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on framebuffer contents: a fixed address-derived pattern.
  function automatic logic [7:0] ramInit(input int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Framebuffer model: written locations overlay the power-on pattern;
  // reads are synchronous with one cycle of latency.
  bit       written [DEPTH];
  bit [7:0] wmem    [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_we && (bus.mem_addr < 15'(DEPTH))) begin
      written[bus.mem_addr] <= 1'b1;
      wmem[bus.mem_addr]    <= bus.mem_wdata;
    end
    if (bus.mem_addr < 15'(DEPTH)) begin
      bus.mem_rdata <= written[bus.mem_addr] ? wmem[bus.mem_addr] : ramInit(int'(bus.mem_addr));
    end else begin
      bus.mem_rdata <= 8'h00;
    end
  end

  // Safety net so a stuck run still terminates.
  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
    tick();
    bus.hCount = h;
    bus.vCount = v;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    bus.hCount        = 10'd0;
    bus.vCount        = 10'd0;
    bus.wr_blank_only = 1'b0;
    bus.wr_req        = 2'b01;
    bus.wr_addr0      = 15'd3;
    bus.wr_addr1      = 15'd4;
    bus.wr_data0      = 8'h11;
    bus.wr_data1      = 8'h22;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.wr_ack, bus.wr_err, bus.mem_we, bus.frame_start} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b required 00000",
               {bus.wr_ack, bus.wr_err, bus.mem_we, bus.frame_start});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.pix_data} !== 31'd0) begin
      fails++;
      $display("[TB] FAIL reset_data: addr %0d wdata %0h pix %0h required all 0",
               bus.mem_addr, bus.mem_wdata, bus.pix_data);
    end
    bus.wr_req = 2'b00;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [9:0] hv [4];
    logic [9:0] vv [4];
    int         av [4];
    hv = '{10'd144, 10'd148, 10'd783, 10'd300};
    vv = '{10'd35,  10'd35,  10'd514, 10'd100};
    av = '{0, 1, 19199, 2599};
    applyStimulus(10'd140, 10'd35);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(hv[i], vv[i]);
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 15'(av[i]) || bus.mem_we !== 1'b0) begin
        fails++;
        $display("[TB] FAIL scan_addr[%0d]: got addr %0d we %b required addr %0d we 0",
                 i, bus.mem_addr, bus.mem_we, av[i]);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (bus.pix_data !== ramInit(av[i])) begin
        fails++;
        $display("[TB] FAIL scan_pix[%0d]: got %0h required %0h", i, bus.pix_data, ramInit(av[i]));
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.pix_data !== ramInit(av[i])) begin
        fails++;
        $display("[TB] FAIL scan_pix_hold[%0d]: got %0h required %0h", i, bus.pix_data, ramInit(av[i]));
      end
    end
    applyStimulus(10'd784, 10'd514);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.pix_data !== 8'h00) begin
      fails++;
      $display("[TB] FAIL pix_blank: got %0h required 0", bus.pix_data);
    end
  endtask

  task automatic test_frame_start();
    applyStimulus(10'd799, 10'd524);
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_start_pre: got %b required 0", bus.frame_start);
    end
    applyStimulus(10'd0, 10'd0);
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b1) begin
      fails++;
      $display("[TB] FAIL frame_start_pulse: got %b required 1", bus.frame_start);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_start_end: got %b required 0", bus.frame_start);
    end
    applyStimulus(10'd0, 10'd1);
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_start_v1: got %b required 0", bus.frame_start);
    end
  endtask

  task automatic test_write_visible();
    tick();
    bus.hCount        = 10'd200;
    bus.vCount        = 10'd100;
    bus.wr_blank_only = 1'b0;
    bus.wr_req        = 2'b01;
    bus.wr_addr0      = 15'd5;
    bus.wr_data0      = 8'hA3;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b00 || bus.mem_addr !== 15'd2574 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wr_scan_wins: got ack %b addr %0d we %b required ack 00 addr 2574 we 0",
               bus.wr_ack, bus.mem_addr, bus.mem_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b01 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd5 ||
        bus.mem_wdata !== 8'hA3) begin
      fails++;
      $display("[TB] FAIL wr_grant: got ack %b we %b addr %0d data %0h required 01 1 5 a3",
               bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.wr_req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b00) begin
      fails++;
      $display("[TB] FAIL wr_ack_single: got %b required 00", bus.wr_ack);
    end
    applyStimulus(10'd164, 10'd35);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.pix_data !== 8'hA3) begin
      fails++;
      $display("[TB] FAIL wr_readback: got %0h required a3", bus.pix_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  expAck  [4];
    logic [14:0] expAddr [4];
    expAck  = '{2'b01, 2'b10, 2'b01, 2'b10};
    expAddr = '{15'd100, 15'd200, 15'd100, 15'd200};
    bus.hCount = 10'd10;
    bus.vCount = 10'd5;
    doReset();
    bus.wr_req   = 2'b11;
    bus.wr_addr0 = 15'd100;
    bus.wr_addr1 = 15'd200;
    bus.wr_data0 = 8'h11;
    bus.wr_data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wr_ack !== expAck[i] || bus.mem_addr !== expAddr[i]) begin
        fails++;
        $display("[TB] FAIL rr[%0d]: got ack %b addr %0d required ack %b addr %0d",
                 i, bus.wr_ack, bus.mem_addr, expAck[i], expAddr[i]);
      end
      tick();
    end
    bus.wr_req = 2'b00;
  endtask

  task automatic test_blank_only();
    int earlyAck;
    earlyAck = 0;
    tick();
    bus.hCount        = 10'd200;
    bus.vCount        = 10'd100;
    bus.wr_blank_only = 1'b1;
    bus.wr_req        = 2'b01;
    bus.wr_addr0      = 15'd6;
    bus.wr_data0      = 8'h5C;
    for (int h = 200; h <= 780; h += 4) begin
      bus.hCount = 10'(h);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (bus.wr_ack !== 2'b00) earlyAck++;
        tick();
      end
    end
    bus.hCount = 10'd784;
    @(negedge clk);
    checks++;
    if (earlyAck !== 0) begin
      fails++;
      $display("[TB] FAIL blank_only_early: got %0d visible acks required 0", earlyAck);
    end
    checks++;
    if (bus.wr_ack !== 2'b01 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd6) begin
      fails++;
      $display("[TB] FAIL blank_only_grant: got ack %b we %b addr %0d required 01 1 6",
               bus.wr_ack, bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.wr_req        = 2'b00;
    bus.wr_blank_only = 1'b0;
  endtask

  task automatic test_bad_addr();
    tick();
    bus.wr_req   = 2'b10;
    bus.wr_addr1 = 15'd19200;
    bus.wr_data1 = 8'h77;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b10 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_addr_ack: got ack %b we %b required ack 10 we 0",
               bus.wr_ack, bus.mem_we);
    end
    tick();
    bus.wr_req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.wr_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bad_addr_err: got %b required 1", bus.wr_err);
    end
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    checks++;
    if (bus.wr_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bad_addr_sticky: got %b required 1", bus.wr_err);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_addr_clear: got %b required 0", bus.wr_err);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_grant();
    tick();
    bus.wr_req   = 2'b01;
    bus.wr_addr0 = 15'd7;
    bus.wr_data0 = 8'h42;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.wr_ack !== 2'b01) begin
      fails++;
      $display("[TB] FAIL mid_grant_pre: got we %b ack %b required 1 01", bus.mem_we, bus.wr_ack);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_ack, bus.wr_err, bus.mem_we, bus.frame_start} !== 5'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.pix_data} !== 31'd0) begin
      fails++;
      $display("[TB] FAIL mid_grant_reset: got ack %b we %b addr %0d wdata %0h required all 0",
               bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b00 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_grant_held: got ack %b we %b required 00 0", bus.wr_ack, bus.mem_we);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b01 || bus.mem_addr !== 15'd7 || bus.mem_we !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_grant_reissue: got ack %b addr %0d we %b required 01 7 1",
               bus.wr_ack, bus.mem_addr, bus.mem_we);
    end
    tick();
    bus.wr_req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_grant_once: got %b required 00", bus.wr_ack);
    end
    tick();
    bus.wr_req   = 2'b11;
    bus.wr_addr1 = 15'd8;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 2'b10) begin
      fails++;
      $display("[TB] FAIL mid_grant_rr: got %b required 10", bus.wr_ack);
    end
    tick();
    bus.wr_req = 2'b00;
  endtask

  // Scenarios run back to back; each leaves the raster in blanking.
  initial begin
    checks = 0;
    fails  = 0;
    $display("[TB] starting fb_access_arbiter bench");
    test_reset();
    test_scan();
    test_frame_start();
    test_write_visible();
    bus.hCount = 10'd790;
    bus.vCount = 10'd520;
    test_round_robin();
    test_blank_only();
    test_bad_addr();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Arbitrates the single port of the 160x120 framebuffer RAM between the VGA scan-out path and two game-logic write requesters. It runs on the 100 MHz system clock and watches the hCount/vCount raster from the VGA timing block. On every new visible pixel it issues one scan read with absolute priority, and it returns the pixel on pix_data. All other cycles go to writers, granted round-robin, with an optional blanking-only mode for tear-free updates.

## Interface
Parameters:
- DATA_W, 8: framebuffer word (pixel colour) width.
- ADDR_W, 15: framebuffer address width; valid range 0..19199.

Ports:
- clk  in  1  system clock (100 MHz; the raster advances once per 4 clk).
- reset_n  in  1  asynchronous, active-low reset.
- hCount  in  10  horizontal raster count from the VGA timing block, 0..799.
- vCount  in  10  vertical raster count, 0..524.
- wr_blank_only  in  1  when 1, writes are granted only outside the visible window.
- wr_req  in  2  per-requester write request; level, held until the matching ack.
- wr_addr0 / wr_addr1  in  ADDR_W  write address, requester 0 / 1.
- wr_data0 / wr_data1  in  DATA_W  write data, requester 0 / 1.
- wr_ack  out  2  one-cycle pulse; the write was performed or discarded this cycle.
- wr_err  out  1  sticky flag: an out-of-range write address was acked.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.
- pix_data  out  DATA_W  current pixel colour; 0 outside the visible window.
- frame_start  out  1  one-cycle pulse when the raster wraps to (0,0).

## Operation
- Visible window: hCount 144..783 and vCount 35..514, inclusive.
- Raster change detection:
  - hCount is registered into h_d every clk.
  - new_px = (hCount != h_d).
  - h_d resets to 0.
- Scan fetch: a scan cycle occurs when new_px=1 and the raster is in the visible window.
  - x = (hCount-144)>>2, giving 0..159.
  - y = (vCount-35)>>2, giving 0..119.
  - mem_addr = y*160 + x, computed as (y<<7)+(y<<5)+x.
  - mem_we = 0.
- Write slot: any cycle that is not a scan cycle. A write is eligible when:
  - wr_req is nonzero, and
  - wr_blank_only=0 or the raster is outside the visible window.
- Round-robin arbitration:
  - Pointer rr (1 bit) resets to 0.
  - If both requesters are eligible, grant requester rr.
  - If only one is eligible, grant that one.
  - After any grant, rr becomes the index of the requester not granted.
- Grant cycle:
  - mem_addr and mem_wdata are driven from the granted requester.
  - wr_ack[g] pulses in the same cycle.
  - mem_we = 1 if addr <= 19199. Otherwise mem_we = 0 and wr_err is set.
- Requesters may present the next transfer on the cycle after their ack. Back-to-back writes by one requester are allowed when the other requester is idle.
- When idle (no scan, no grant): mem_we = 0 and mem_addr holds its last value.
- pix_data:
  - Loaded from mem_rdata on the cycle after each scan cycle.
  - Held until the next load.
  - Cleared to 0 on the first cycle the raster is outside the visible window.
- frame_start pulses when new_px=1 and hCount=0 and vCount=0.
- wr_err clears only on reset.

## Timing
- Reset: every output is 0; h_d=0; rr=0.
- Scan read latency: hCount changes at clk N; the scan cycle is N; pix_data is valid at N+2 and stays stable through the end of that pixel (4-clk period).
- At most one scan cycle per 4 clk, so at least 3 write slots per visible pixel. During blanking every cycle is a write slot.
- Simultaneous scan and wr_req: the scan wins, no ack is given, and the request is retried the next cycle.
- Reset asserted mid-grant: mem_we drops to 0 immediately (async). The pending write is lost and never acked; requesters re-issue after reset.
- wr_blank_only toggling takes effect in the same cycle; requests already acked are unaffected.

## Test plan
- Raster at (h=144,v=35), then (148,35): scan cycles at mem_addr 0 then 1. At (783,514): mem_addr 19199. pix_data equals the RAM contents 2 clk after each hCount change.
- wr_req=2'b01 with addr 5, data 0xA3, during the visible region: ack within 2 clk and never in a scan cycle. A read-back of address 5 returns 0xA3.
- wr_req=2'b11 held continuously in blanking: acks alternate 01,10,01,10 on consecutive cycles, starting with 01 after reset.
- wr_blank_only=1 with a request raised at (h=200,v=100): no ack until hCount=784. The ack comes at the first clk with hCount>=784.
- Write to addr 19200: wr_ack pulses, mem_we stays 0, wr_err=1 and remains 1 until reset_n=0.
- reset_n pulsed low while wr_req=01 during a grant: all outputs read 0 during reset. After release, the held request is acked once and rr=1.
